// File: rtl/hypot_sched_pkg.sv
// Shared types and constants for the hypotenuse scheduler.
package hypot_pkg;

    localparam int W_DEF   = 8;
    localparam int RES_W   = W_DEF + 1;
    localparam int SUM_W   = 2 * W_DEF + 1;
    localparam int LATENCY = (W_DEF + 1) * (W_DEF + 4) + 2;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQX,
        S_SQY,
        S_SUM,
        S_ROOT,
        S_DONE
    } state_e;

endpackage

// File: rtl/hypot_sched_sq_unit.sv
// Iterative shift-add squarer: one multiplier bit per cycle, LSB first.
// The start cycle already consumes bit 0, so the product appears on prod_o in the done cycle.
module hypot_sq_unit #(
    parameter int OW = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic            start_i,
    input  logic [OW-1:0]   op_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [2*OW-1:0] prod_o
);

    localparam int PW = 2 * OW;
    localparam int CW = (OW > 1) ? $clog2(OW + 1) : 1;

    logic [PW-1:0] acc_q, mcand_q, mcand, acc_base, acc_d;
    logic [OW-1:0] mplier_q, mplier;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    always_comb begin
        mcand    = start_i ? PW'(op_i) : mcand_q;
        mplier   = start_i ? op_i : mplier_q;
        acc_base = start_i ? '0 : acc_q;
        acc_d    = acc_base + (mplier[0] ? mcand : '0);
    end

    assign busy_o = run_q;
    assign done_o = en_i && run_q && (cnt_q == CW'(OW - 1));
    assign prod_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (en_i) begin
            if (start_i || run_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand << 1;
                mplier_q <= mplier >> 1;
            end
            if (start_i) begin
                run_q <= 1'b1;
                cnt_q <= CW'(1);
            end else if (run_q) begin
                cnt_q <= cnt_q + CW'(1);
                if (cnt_q == CW'(OW - 1)) run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hypot_sched.sv
// Two-client hypotenuse engine: round-robin accept, then x^2, y^2 and a
// bit-serial square root all sequenced on one shared squarer.
module hypot_sched
    import hypot_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         req_a,
    input  logic [W-1:0] x_a,
    input  logic [W-1:0] y_a,
    output logic         gnt_a,
    input  logic         req_b,
    input  logic [W-1:0] x_b,
    input  logic [W-1:0] y_b,
    output logic         gnt_b,
    output logic         busy,
    output logic         res_valid,
    output logic         res_id,
    output logic [W:0]   res
);

    localparam int RW = W + 1;
    localparam int SW = 2 * W + 1;
    localparam int PW = 2 * W + 2;
    localparam int IW = $clog2(RW);

    state_e        state_q, state_d;
    logic          last_q, last_d, id_q, id_d, cmp_q, cmp_d, res_id_q, res_id_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d;
    logic [PW-1:0] xsq_q, xsq_d, ysq_q, ysq_d, tsq_q, tsq_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [RW-1:0] r_q, r_d, res_q, res_d, trial, sq_op;
    logic [IW-1:0] bit_q, bit_d;
    logic          grant_a, grant_b;
    logic          sq_start, sq_run, sq_done;
    logic [PW-1:0] sq_prod;

    assign trial = r_q | (RW'(1) << bit_q);

    hypot_sq_unit #(.OW(RW)) u_sq (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ena),
        .start_i (sq_start),
        .op_i    (sq_op),
        .busy_o  (sq_run),
        .done_o  (sq_done),
        .prod_o  (sq_prod)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        cmp_d    = cmp_q;
        res_id_d = res_id_q;
        x_d      = x_q;
        y_d      = y_q;
        xsq_d    = xsq_q;
        ysq_d    = ysq_q;
        tsq_d    = tsq_q;
        sum_d    = sum_q;
        r_d      = r_q;
        res_d    = res_q;
        bit_d    = bit_q;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        sq_start = 1'b0;
        sq_op    = '0;
        if (ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_a && (!req_b || last_q == ID_B)) grant_a = 1'b1;
                    else if (req_b)                          grant_b = 1'b1;
                    if (grant_a) begin
                        x_d = x_a; y_d = y_a; id_d = ID_A; last_d = ID_A;
                        state_d = S_SQX;
                    end else if (grant_b) begin
                        x_d = x_b; y_d = y_b; id_d = ID_B; last_d = ID_B;
                        state_d = S_SQX;
                    end
                end
                S_SQX: begin
                    sq_op    = {1'b0, x_q};
                    sq_start = !sq_run;
                    if (sq_done) begin
                        xsq_d   = sq_prod;
                        state_d = S_SQY;
                    end
                end
                S_SQY: begin
                    sq_op    = {1'b0, y_q};
                    sq_start = !sq_run;
                    if (sq_done) begin
                        ysq_d   = sq_prod;
                        state_d = S_SUM;
                    end
                end
                S_SUM: begin
                    sum_d   = SW'(xsq_q + ysq_q);
                    r_d     = '0;
                    bit_d   = IW'(W);
                    cmp_d   = 1'b0;
                    state_d = S_ROOT;
                end
                S_ROOT: begin
                    // Each trial: W+1 squaring cycles, then one compare cycle.
                    if (!cmp_q) begin
                        sq_op    = trial;
                        sq_start = !sq_run;
                        if (sq_done) begin
                            tsq_d = sq_prod;
                            cmp_d = 1'b1;
                        end
                    end else begin
                        if (tsq_q <= PW'(sum_q)) r_d = trial;
                        cmp_d = 1'b0;
                        if (bit_q == IW'(0)) state_d = S_DONE;
                        else                 bit_d   = bit_q - IW'(1);
                    end
                end
                S_DONE: begin
                    res_d    = r_q;
                    res_id_d = id_q;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= ID_B;
            id_q     <= ID_A;
            cmp_q    <= 1'b0;
            res_id_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            xsq_q    <= '0;
            ysq_q    <= '0;
            tsq_q    <= '0;
            sum_q    <= '0;
            r_q      <= '0;
            res_q    <= '0;
            bit_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            cmp_q    <= cmp_d;
            res_id_q <= res_id_d;
            x_q      <= x_d;
            y_q      <= y_d;
            xsq_q    <= xsq_d;
            ysq_q    <= ysq_d;
            tsq_q    <= tsq_d;
            sum_q    <= sum_d;
            r_q      <= r_d;
            res_q    <= res_d;
            bit_q    <= bit_d;
        end
    end

    // The result is visible in the DONE cycle itself and held afterwards.
    assign gnt_a     = grant_a & rst_n;
    assign gnt_b     = grant_b & rst_n;
    assign busy      = (state_q != S_IDLE);
    assign res_valid = ena && (state_q == S_DONE);
    assign res       = (state_q == S_DONE) ? r_q  : res_q;
    assign res_id    = (state_q == S_DONE) ? id_q : res_id_q;

endmodule
